// File: rtl/lab2_7_tester_if.sv
// Connection bundle between the truth-table tester and the block it exercises.
// The tester owns the stimulus and status; the checked side returns z_in.
interface lab2_7_tester_if #(
  parameter int N = 3
);
  logic         start;
  logic         z_in;
  logic [N-1:0] x;
  logic         busy;
  logic         done;
  logic         pass;
  logic [7:0]   err_count;
  logic         fail_seen;
  logic [N-1:0] first_fail_x;

  modport master (
    input  start, z_in,
    output x, busy, done, pass, err_count, fail_seen, first_fail_x
  );

  modport slave (
    output start, z_in,
    input  x, busy, done, pass, err_count, fail_seen, first_fail_x
  );
endinterface

// File: rtl/lab2_7_tester.sv
// Stimulus initiator and checker for an N-input truth-table block: sweeps x,
// realigns the delayed response z_in and tallies mismatches per run.
module lab2_7_tester #(
  parameter int                 N           = 3,
  parameter logic [(1<<N)-1:0]  TRUTH_TABLE = 8'b00111001,
  parameter int                 LATENCY     = 2,
  parameter int                 PASSES      = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  lab2_7_tester_if.master   bus
);

  localparam logic [N-1:0] X_MAX     = {N{1'b1}};
  localparam logic [N-1:0] X_PENULT  = X_MAX - N'(1);
  localparam logic [4:0]   PASS_LAST = 5'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state_r, state_nxt_s;
  logic         start_acc_s, issue_s, last_issue_s;
  logic [N-1:0] x_r;
  logic [4:0]   pass_cnt_r;
  logic         busy_r, done_r, pass_r, fail_seen_r;
  logic [7:0]   err_r, err_nxt_s;
  logic [N-1:0] first_fail_r;

  // Compare pipeline: one (valid, last, x) entry per issued vector.
  logic [LATENCY:0] vld_r;
  logic [LATENCY:0] last_r;
  logic [N-1:0]     px_r [LATENCY+1];

  logic cmp_vld_s, cmp_last_s, mism_s;

  // Oldest pipeline entry meets the z_in sample it belongs to.
  always_comb begin
    cmp_vld_s  = vld_r[LATENCY];
    cmp_last_s = vld_r[LATENCY] & last_r[LATENCY];
    mism_s     = vld_r[LATENCY] & (bus.z_in != TRUTH_TABLE[px_r[LATENCY]]);
    if (mism_s && (err_r != 8'hFF)) begin
      err_nxt_s = err_r + 8'd1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-cycle issue strobes; with LATENCY==0 the final
  // compare lands one edge after the last issue, so RUN closes the run itself.
  always_comb begin
    state_nxt_s  = state_r;
    start_acc_s  = 1'b0;
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_acc_s = 1'b1;
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_RUN: begin
        if (cmp_last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          issue_s      = 1'b1;
          last_issue_s = (x_r == X_PENULT) && (pass_cnt_r == PASS_LAST);
          if (last_issue_s && (LATENCY != 0)) begin
            state_nxt_s = S_DRAIN;
          end else begin
            state_nxt_s = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (cmp_last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Compare pipeline shift; bubbles enter whenever nothing is issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_r  <= '0;
      last_r <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        px_r[k] <= {N{1'b0}};
      end
    end else begin
      vld_r[0]  <= start_acc_s | issue_s;
      last_r[0] <= issue_s & last_issue_s;
      px_r[0]   <= start_acc_s ? {N{1'b0}} : (x_r + N'(1));
      for (int k = 1; k <= LATENCY; k++) begin
        vld_r[k]  <= vld_r[k-1];
        last_r[k] <= last_r[k-1];
        px_r[k]   <= px_r[k-1];
      end
    end
  end

  // Stimulus counter, error tally and run status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_r          <= {N{1'b0}};
      pass_cnt_r   <= 5'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= 8'd0;
      fail_seen_r  <= 1'b0;
      first_fail_r <= {N{1'b0}};
    end else if (start_acc_s) begin
      x_r          <= {N{1'b0}};
      pass_cnt_r   <= 5'd0;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= 8'd0;
      fail_seen_r  <= 1'b0;
      first_fail_r <= {N{1'b0}};
    end else begin
      if (issue_s) begin
        x_r <= x_r + N'(1);
        if (x_r == X_MAX) begin
          pass_cnt_r <= pass_cnt_r + 5'd1;
        end
      end
      if (cmp_vld_s) begin
        err_r <= err_nxt_s;
      end
      if (mism_s && !fail_seen_r) begin
        fail_seen_r  <= 1'b1;
        first_fail_r <= px_r[LATENCY];
      end
      if (cmp_last_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        pass_r <= (err_nxt_s == 8'd0);
      end
    end
  end

  assign bus.x            = x_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.pass         = pass_r;
  assign bus.err_count    = err_r;
  assign bus.fail_seen    = fail_seen_r;
  assign bus.first_fail_x = first_fail_r;

endmodule

// File: tb/tb_lab2_7_tester.sv
// Bench for lab2_7_tester: three instances (latency 2/1/0, passes 1/2/1) driven
// by a behavioural function-block model with a per-run error mask on z.
module tb_lab2_7_tester;

  localparam logic [7:0] TT = 8'b00111001;

  logic clock = 1'b0;
  logic reset_n;
  logic start_s;
  logic [7:0] mask;

  always #5 clock = ~clock;

  lab2_7_tester_if #(.N(3)) ifa ();
  lab2_7_tester_if #(.N(3)) ifb ();
  lab2_7_tester_if #(.N(3)) ifc ();

  lab2_7_tester #(.N(3), .TRUTH_TABLE(TT), .LATENCY(2), .PASSES(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa.master));
  lab2_7_tester #(.N(3), .TRUTH_TABLE(TT), .LATENCY(1), .PASSES(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb.master));
  lab2_7_tester #(.N(3), .TRUTH_TABLE(TT), .LATENCY(0), .PASSES(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(ifc.master));

  // Function block under test, with mask bit k flipping its answer for x == k.
  logic za0, za1, za2, zb0, zb1, zc0;
  assign za0 = TT[ifa.x] ^ mask[ifa.x];
  assign zb0 = TT[ifb.x] ^ mask[ifb.x];
  assign zc0 = TT[ifc.x] ^ mask[ifc.x];
  always @(posedge clock) begin
    za1 <= za0;
    za2 <= za1;
    zb1 <= zb0;
  end
  assign ifa.z_in  = za2;
  assign ifb.z_in  = zb1;
  assign ifc.z_in  = zc0;
  assign ifa.start = start_s;
  assign ifb.start = start_s;
  assign ifc.start = start_s;

  logic [2:0] x_v [3];
  logic       busy_v [3], done_v [3], pass_v [3], fail_v [3];
  logic [7:0] err_v [3];
  logic [2:0] first_v [3];
  assign x_v[0] = ifa.x;             assign x_v[1] = ifb.x;             assign x_v[2] = ifc.x;
  assign busy_v[0] = ifa.busy;       assign busy_v[1] = ifb.busy;       assign busy_v[2] = ifc.busy;
  assign done_v[0] = ifa.done;       assign done_v[1] = ifb.done;       assign done_v[2] = ifc.done;
  assign pass_v[0] = ifa.pass;       assign pass_v[1] = ifb.pass;       assign pass_v[2] = ifc.pass;
  assign fail_v[0] = ifa.fail_seen;  assign fail_v[1] = ifb.fail_seen;  assign fail_v[2] = ifc.fail_seen;
  assign err_v[0] = ifa.err_count;   assign err_v[1] = ifb.err_count;   assign err_v[2] = ifc.err_count;
  assign first_v[0] = ifa.first_fail_x; assign first_v[1] = ifb.first_fail_x; assign first_v[2] = ifc.first_fail_x;

  int lat_t [3] = '{2, 1, 0};
  int pas_t [3] = '{1, 2, 1};

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [7:0] m);
    int c = 0;
    for (int b = 0; b < 8; b++) c += int'(m[b]);
    return c;
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) return b;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("%s_x%0d", tag, k), 32'(x_v[k]), 32'd0);
      check_val($sformatf("%s_busy%0d", tag, k), 32'(busy_v[k]), 32'd0);
      check_val($sformatf("%s_done%0d", tag, k), 32'(done_v[k]), 32'd0);
      check_val($sformatf("%s_pass%0d", tag, k), 32'(pass_v[k]), 32'd0);
      check_val($sformatf("%s_err%0d", tag, k), 32'(err_v[k]), 32'd0);
      check_val($sformatf("%s_fseen%0d", tag, k), 32'(fail_v[k]), 32'd0);
      check_val($sformatf("%s_first%0d", tag, k), 32'(first_v[k]), 32'd0);
    end
  endtask

  // One full run: start at edge s, cycle-exact x/busy/done, then final results.
  task automatic do_run(input logic [7:0] m, input bit pulse_mid, input string tag);
    int v, fin, xe, cnt;
    mask = m;
    @(negedge clock);
    start_s = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clock);
      if (i == 0) start_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
        v   = pas_t[k] * 8;
        fin = v + lat_t[k];
        xe  = (i < v) ? (i % 8) : 7;
        check_val($sformatf("%s_x%0d_e%0d", tag, k, i), 32'(x_v[k]), 32'(xe));
        check_val($sformatf("%s_busy%0d_e%0d", tag, k, i), 32'(busy_v[k]), (i < fin) ? 32'd1 : 32'd0);
        check_val($sformatf("%s_done%0d_e%0d", tag, k, i), 32'(done_v[k]), (i >= fin) ? 32'd1 : 32'd0);
        if (i == 0) begin
          check_val($sformatf("%s_clr_err%0d", tag, k), 32'(err_v[k]), 32'd0);
          check_val($sformatf("%s_clr_fseen%0d", tag, k), 32'(fail_v[k]), 32'd0);
          check_val($sformatf("%s_clr_first%0d", tag, k), 32'(first_v[k]), 32'd0);
          check_val($sformatf("%s_clr_pass%0d", tag, k), 32'(pass_v[k]), 32'd0);
        end
      end
      if (pulse_mid && i == 2) start_s = 1'b1;
      if (pulse_mid && i == 3) start_s = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      cnt = popc(m) * pas_t[k];
      if (cnt > 255) cnt = 255;
      check_val($sformatf("%s_err%0d", tag, k), 32'(err_v[k]), 32'(cnt));
      check_val($sformatf("%s_fseen%0d", tag, k), 32'(fail_v[k]), (m != 8'd0) ? 32'd1 : 32'd0);
      check_val($sformatf("%s_first%0d", tag, k), 32'(first_v[k]), 32'(lowest(m)));
      check_val($sformatf("%s_pass%0d", tag, k), 32'(pass_v[k]), (m == 8'd0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_s = 1'b0;
    mask    = 8'd0;
    #3;
    check_all_zero("por");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_all_zero("idle");

    do_run(8'd0, 1'b0, "clean");
    do_run(TT, 1'b0, "stuck0");
    do_run(~TT, 1'b1, "stuck1_midstart");
    do_run(8'h40, 1'b0, "inv6");
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      do_run(($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom), 1'b0, $sformatf("rnd%0d", r));
    end

    // Abort a faulty run with reset, then confirm a clean run afterwards.
    mask = 8'hFF;
    @(negedge clock);
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_all_zero("rst_idle");
    do_run(8'd0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lab2_7_tester.md
Name: lab2_7_tester

Overview:
- Self-checking stimulus initiator for the 3-input truth-table function block and its two-stage registered output chain.
- On `start`, drives every input combination onto `x` once per clock.
- Captures the returned delayed response `z_in` and compares each sample against a parameterised truth table, aligned by a configurable pipeline latency.
- Reports mismatch count, first failing vector and pass/fail status. It sits beside the function block on the lab board/bench as its driver and checker.

Parameters:
- N, 3, input vector width; vectors per pass = 2^N.
- TRUTH_TABLE, 8'b00111001, expected output; bit k is the expected z for x == k (width 2^N).
- LATENCY, 2, clock edges from an x update to z_in carrying the matching result (2 = D_d2, 1 = D_d1, 0 = combinational z).
- PASSES, 1, number of full sweeps per run (1..16).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled on the rising edge.
- z_in  input  1  response from the checked block, tap selected by LATENCY.
- x  output  N  registered stimulus to the checked block.
- busy  output  1  high while a run is in progress.
- done  output  1  level; high from run completion until the next accepted start or reset.
- pass  output  1  valid while done is high; 1 iff err_count == 0.
- err_count  output  8  mismatch count, saturating at 255.
- fail_seen  output  1  at least one mismatch in the current run.
- first_fail_x  output  N  x value of the first mismatch; 0 if none.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0; stimulus counter, pass counter and compare pipeline cleared.
- Reset mid-run aborts immediately with no partial result kept.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: last vector issued -> DRAIN; if LATENCY==0, -> DONE directly after the final compare.
  - DRAIN: last compare done -> DONE.
  - DONE: start=1 -> RUN.
- start is ignored in RUN and DRAIN.
- Accepting start at edge s:
  - x<=0, busy<=1, done<=0, pass<=0.
  - err_count, fail_seen and first_fail_x cleared at that same edge.
- Issue schedule:
  - Vector i (i = 0..V-1, V = PASSES*2^N) is driven on x from edge s+i.
  - x increments mod 2^N each cycle and wraps 2^N-1 -> 0 between passes.
  - After the last vector, x holds its final value (2^N-1) until the next start.
- Compare pipeline:
  - A LATENCY+1 deep shift register carries (valid, x) for each issued vector.
  - The entry for vector i is compared at edge s+i+LATENCY+1: z_in against TRUTH_TABLE[x_i].
- On mismatch:
  - err_count increments (saturating at 255).
  - If fail_seen==0: fail_seen<=1 and first_fail_x<=x_i, both updated at that same edge.
- Completion:
  - The final compare occurs at edge s+V+LATENCY.
  - At that same edge: state DONE, busy<=0, done<=1, and pass<=1 iff the final count (including this compare) is 0.
- No overlap: a new run cannot start until DONE, so no stale pipeline entries exist at run start.
- PASSES>1: each pass counts errors again; first_fail_x keeps the first failure of the run.

Test Plan:
1. Reset during activity -> all outputs 0 and x=0 immediately, before any clock edge; with start held low, the block stays IDLE.
2. Correct reference model on z_in (LATENCY=2, PASSES=1), start at edge s -> x = 0,1,...,7 on edges s..s+7; busy=1 over that window; done=1 and pass=1 after edge s+10; err_count=0.
3. z_in stuck at 0 -> mismatches for x = 0,3,4,5; err_count=4, first_fail_x=0, fail_seen=1, pass=0. With PASSES=2 -> err_count=8.
4. Model inverted only for x=6 -> err_count=1, first_fail_x=6, pass=0. With z_in stuck at 1 -> err_count=4, first_fail_x=1.
5. Pulse start during RUN at edge s+3 -> ignored; x sequence and completion timing unchanged. Pulse start in DONE -> counters clear and a new run starts, x=0 on the next edge.
6. reset_n low at edge s+4 of a faulty run, then release and start with a correct model -> clean run: err_count=0, pass=1, done after edge s'+10.
